// File: rtl/instr_fetcher_pkg.sv
// instr_fetcher_pkg: shared opcodes, FSM encoding, queue entry layout and static branch predictor
package instr_fetcher_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic pred_taken;
    logic [DATA_W-1:0] pred_pc;
  } iq_entry_t;
  function automatic iq_entry_t predict(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] j_imm, b_imm;
    logic jal, br;
    j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    jal = instr[6:0] == OP_JAL;
    br = instr[6:0] == OP_BR && instr[31];
    return '{instr: instr, pc: pc, pred_taken: jal | br,
             pred_pc: pc + (jal ? j_imm : br ? b_imm : 32'd4)};
  endfunction
endpackage

// File: rtl/instr_fetcher_queue.sv
// instr_queue: circular FIFO of fetched entries with synchronous clear and combinational head
module instr_queue
  import instr_fetcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  iq_entry_t push_data,
  output iq_entry_t head,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  iq_entry_t mem [DEPTH];
  logic [AW-1:0] hd, tl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else if (en && clr) begin
      hd <= '0;
      tl <= '0;
      count <= '0;
    end else if (en) begin
      tl <= tl + AW'(push);
      hd <= hd + AW'(pop);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  always_ff @(posedge clk)
    if (en && push && !clr) mem[tl] <= push_data;
  assign head = mem[hd];
  assign valid = count != '0;
endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: single-outstanding fetch FSM feeding a predicted-instruction queue
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 8
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  output logic mc_req_valid,
  output logic [31:0] mc_req_addr,
  input  logic mc_resp_valid,
  input  logic [31:0] mc_resp_data,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic iq_valid,
  input  logic iq_ready,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic iq_pred_taken,
  output logic [31:0] iq_pred_pc
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(IQ_DEPTH);
  state_t state, state_n;
  logic [31:0] pc, pc_n, addr_n;
  logic req_n, push, pop, clr, q_valid;
  logic [CW-1:0] count;
  iq_entry_t head, entry;
  assign entry = predict(mc_resp_data, pc);
  assign pop = q_valid && iq_ready && !redirect_valid;
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_n = mc_req_valid;
    addr_n = mc_req_addr;
    push = 1'b0;
    clr = 1'b0;
    if (redirect_valid) begin
      clr = 1'b1;
      pc_n = redirect_pc;
      // A response landing with the redirect retires the outstanding request
      if (state != IDLE && mc_resp_valid) begin
        state_n = IDLE;
        req_n = 1'b0;
      end else if (state == WAIT) state_n = DROP;
    end else if (state == IDLE) begin
      if (count != FULL) begin
        state_n = WAIT;
        req_n = 1'b1;
        addr_n = {pc[31:2], 2'b00};
      end
    end else if (mc_resp_valid) begin
      push = state == WAIT;
      pc_n = state == WAIT ? entry.pred_pc : pc;
      state_n = IDLE;
      req_n = 1'b0;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      pc <= '0;
      mc_req_valid <= 1'b0;
      mc_req_addr <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      pc <= pc_n;
      mc_req_valid <= req_n;
      mc_req_addr <= addr_n;
    end
  instr_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk(clk_in),
    .rst_n(rst_n_in),
    .en(rdy_in),
    .clr(clr),
    .push(push),
    .pop(pop),
    .push_data(entry),
    .head(head),
    .valid(q_valid),
    .count(count)
  );
  assign iq_valid = q_valid && rdy_in;
  assign iq_instr = q_valid ? head.instr : '0;
  assign iq_pc = q_valid ? head.pc : '0;
  assign iq_pred_taken = q_valid && head.pred_taken;
  assign iq_pred_pc = q_valid ? head.pred_pc : '0;
endmodule
